ctrl_pipe: RTL

Pipelined RV32I control unit. Decodes the instruction held in IF/ID and registers the full control bundle into an ID/EX control register. Adds what a pure single-cycle decoder cannot do: valid/ready handshake, load-use hazard stall, branch flush, illegal-instruction flagging and stall/flush event counters. Sits between the IF/ID register and the EX stage of the 5-stage core.

---
 rtl/ctrl_pkg.sv | 79 +++++++
 rtl/ctrl_decode.sv | 175 +++++++++++++++++
 rtl/ctrl_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I pipelined control unit: opcodes, control-field
// codes, the ALU operation list and the ID/EX control bundle layout.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [5:0] EXT_NONE  = 6'b000000;
  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  localparam logic [2:0] NPC_PC4  = 3'b000;
  localparam logic [2:0] NPC_BR   = 3'b001;
  localparam logic [2:0] NPC_JAL  = 3'b010;
  localparam logic [2:0] NPC_JALR = 3'b100;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [4:0] {
    ALU_NONE  = 5'b00000,
    ALU_LUI   = 5'b00001,
    ALU_AUIPC = 5'b00010,
    ALU_ADD   = 5'b00011,
    ALU_SUB   = 5'b00100,
    ALU_BNE   = 5'b00101,
    ALU_BLT   = 5'b00110,
    ALU_BGE   = 5'b00111,
    ALU_BLTU  = 5'b01000,
    ALU_BGEU  = 5'b01001,
    ALU_SLT   = 5'b01010,
    ALU_SLTU  = 5'b01011,
    ALU_XOR   = 5'b01100,
    ALU_OR    = 5'b01101,
    ALU_AND   = 5'b01110,
    ALU_SLL   = 5'b01111,
    ALU_SRL   = 5'b10000,
    ALU_SRA   = 5'b10001
  } alu_op_e;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic [5:0] ext_op;
    logic [4:0] alu_op;
    logic [2:0] npc_op;
    logic [1:0] wd_sel;
    logic [2:0] dm_type;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational RV32I decoder: instruction word to control fields, plus
// the illegal-encoding flag and which source registers the instruction reads.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        reg_write,
  output logic        mem_write,
  output logic        mem_read,
  output logic        alu_src,
  output logic [5:0]  ext_op,
  output logic [4:0]  alu_op,
  output logic [2:0]  npc_op,
  output logic [1:0]  wd_sel,
  output logic [2:0]  dm_type,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        illegal,
  output logic        rs1_used,
  output logic        rs2_used
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       r_funct_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Only add/sub and srl/sra may carry the alternate funct7.
  assign r_funct_ok = (funct7 == F7_ZERO) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    alu_src   = 1'b0;
    ext_op    = EXT_NONE;
    alu_op    = ALU_NONE;
    npc_op    = NPC_PC4;
    wd_sel    = WD_ALU;
    dm_type   = DM_W;
    illegal   = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;

    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        illegal   = !r_funct_ok;
        case (funct3)
          3'b000:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OP_I: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        rs1_used  = 1'b1;
        ext_op    = EXT_I;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            ext_op  = EXT_SHAMT;
            alu_op  = ALU_SLL;
            illegal = (funct7 != F7_ZERO);
          end
          default: begin
            ext_op  = EXT_SHAMT;
            alu_op  = funct7[5] ? ALU_SRA : ALU_SRL;
            illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
          end
        endcase
      end
      OP_LOAD: begin
        reg_write = 1'b1;
        mem_read  = 1'b1;
        alu_src   = 1'b1;
        rs1_used  = 1'b1;
        ext_op    = EXT_I;
        alu_op    = ALU_ADD;
        wd_sel    = WD_MEM;
        case (funct3)
          3'b000:  dm_type = DM_B;
          3'b001:  dm_type = DM_H;
          3'b010:  dm_type = DM_W;
          3'b100:  dm_type = DM_BU;
          3'b101:  dm_type = DM_HU;
          default: illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        ext_op    = EXT_S;
        alu_op    = ALU_ADD;
        case (funct3)
          3'b000:  dm_type = DM_B;
          3'b001:  dm_type = DM_H;
          3'b010:  dm_type = DM_W;
          default: illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        ext_op   = EXT_B;
        npc_op   = NPC_BR;
        case (funct3)
          3'b000:  alu_op = ALU_SUB;
          3'b001:  alu_op = ALU_BNE;
          3'b100:  alu_op = ALU_BLT;
          3'b101:  alu_op = ALU_BGE;
          3'b110:  alu_op = ALU_BLTU;
          3'b111:  alu_op = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        reg_write = 1'b1;
        ext_op    = EXT_J;
        npc_op    = NPC_JAL;
        wd_sel    = WD_PC4;
      end
      OP_JALR: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        rs1_used  = 1'b1;
        ext_op    = EXT_I;
        alu_op    = ALU_ADD;
        npc_op    = NPC_JALR;
        wd_sel    = WD_PC4;
        illegal   = (funct3 != 3'b000);
      end
      OP_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        ext_op    = EXT_U;
        alu_op    = ALU_LUI;
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        ext_op    = EXT_U;
        alu_op    = ALU_AUIPC;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID-stage control unit: decodes IF/ID, detects load-use hazards, and registers
// the control bundle into ID/EX with handshake, flush and event counters.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int HAZ_EN     = 1,
  parameter int ILLEGAL_EN = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [31:0]      id_instr,
  input  logic             ex_ready,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             ex_valid,
  output logic             ex_RegWrite,
  output logic             ex_MemWrite,
  output logic             ex_MemRead,
  output logic             ex_ALUSrc,
  output logic [5:0]       ex_EXTOp,
  output logic [4:0]       ex_ALUOp,
  output logic [2:0]       ex_NPCOp,
  output logic [1:0]       ex_WDSel,
  output logic [2:0]       ex_DMType,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic       dec_reg_write, dec_mem_write, dec_mem_read, dec_alu_src;
  logic [5:0] dec_ext_op;
  logic [4:0] dec_alu_op;
  logic [2:0] dec_npc_op;
  logic [1:0] dec_wd_sel;
  logic [2:0] dec_dm_type;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic       dec_illegal, dec_rs1_used, dec_rs2_used;

  ctrl_decode u_decode (
    .instr     (id_instr),
    .reg_write (dec_reg_write),
    .mem_write (dec_mem_write),
    .mem_read  (dec_mem_read),
    .alu_src   (dec_alu_src),
    .ext_op    (dec_ext_op),
    .alu_op    (dec_alu_op),
    .npc_op    (dec_npc_op),
    .wd_sel    (dec_wd_sel),
    .dm_type   (dec_dm_type),
    .rd        (dec_rd),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .illegal   (dec_illegal),
    .rs1_used  (dec_rs1_used),
    .rs2_used  (dec_rs2_used)
  );

  ctrl_bundle_t     ex_q, ex_d, id_b;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             id_illegal;
  logic             load_use;

  assign id_illegal = (ILLEGAL_EN != 0) && dec_illegal;

  // A load in EX whose destination feeds this instruction cannot forward in time.
  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    id_valid && !flush_i &&
                    ((dec_rs1_used && (dec_rs1 == ex_q.rd)) ||
                     (dec_rs2_used && (dec_rs2 == ex_q.rd)));

  assign stall_o  = (HAZ_EN != 0) && load_use;
  assign id_ready = ex_ready && !stall_o;

  // Illegal encodings must not touch architectural state or redirect the PC.
  always_comb begin
    id_b           = '0;
    id_b.valid     = 1'b1;
    id_b.reg_write = dec_reg_write && !id_illegal;
    id_b.mem_write = dec_mem_write && !id_illegal;
    id_b.mem_read  = dec_mem_read && !id_illegal;
    id_b.alu_src   = dec_alu_src;
    id_b.ext_op    = dec_ext_op;
    id_b.alu_op    = dec_alu_op;
    id_b.npc_op    = id_illegal ? NPC_PC4 : dec_npc_op;
    id_b.wd_sel    = dec_wd_sel;
    id_b.dm_type   = dec_dm_type;
    id_b.rd        = dec_rd;
    id_b.rs1       = dec_rs1;
    id_b.rs2       = dec_rs2;
    id_b.illegal   = id_illegal;
  end

  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_i) begin
      ex_d        = '0;
      flush_cnt_d = (flush_cnt_q == {CNT_W{1'b1}}) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
    end else if (!ex_ready) begin
      ex_d = ex_q;
    end else if (stall_o) begin
      ex_d        = '0;
      stall_cnt_d = (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    end else if (id_valid) begin
      ex_d = id_b;
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_MemWrite = ex_q.mem_write;
  assign ex_MemRead  = ex_q.mem_read;
  assign ex_ALUSrc   = ex_q.alu_src;
  assign ex_EXTOp    = ex_q.ext_op;
  assign ex_ALUOp    = ex_q.alu_op;
  assign ex_NPCOp    = ex_q.npc_op;
  assign ex_WDSel    = ex_q.wd_sel;
  assign ex_DMType   = ex_q.dm_type;
  assign ex_rd       = ex_q.rd;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_illegal  = ex_q.illegal;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
